// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift sequencer: operation codes, FSM states and an op classifier.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SHL = 2'b01,
        OP_ROR = 2'b10,
        OP_SHR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } seq_state_e;

    // Logical shifts saturate their count at the data width; rotations do not.
    function automatic logic is_logical(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/shift_step.sv
// One 1-bit step of a shift or rotate, purely combinational.
module shift_step
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        case (shift_op_e'(op))
            OP_ROL:  out = {in[WIDTH-2:0], in[WIDTH-1]};
            OP_SHL:  out = {in[WIDTH-2:0], 1'b0};
            OP_ROR:  out = {in[0], in[WIDTH-1:1]};
            OP_SHR:  out = {1'b0, in[WIDTH-1:1]};
            default: out = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: latches one request, applies one bit-step per cycle, and holds
// the result until the consumer takes it.
module shift_sequencer
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [SHIFT:0]   req_amount,
    input  logic [1:0]       req_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    localparam int unsigned AMT_W   = SHIFT + 1;
    localparam int unsigned WIDTH_W = $clog2(WIDTH + 1);
    localparam int unsigned CNT_W   = (AMT_W > WIDTH_W) ? AMT_W : WIDTH_W;

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] amt_ext;
    logic [CNT_W-1:0] eff_cnt;
    logic [WIDTH-1:0] step_out;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .in  (data_q),
        .op  (op_q),
        .out (step_out)
    );

    // Effective step count: logical shifts stop at WIDTH, rotations run every step.
    always_comb begin
        amt_ext = CNT_W'(req_amount);
        eff_cnt = amt_ext;
        if (is_logical(req_op) && (amt_ext > CNT_W'(WIDTH))) begin
            eff_cnt = CNT_W'(WIDTH);
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    data_d  = req_data;
                    op_d    = req_op;
                    cnt_d   = eff_cnt;
                    state_d = (eff_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = step_out;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        resp_valid_d = (state_d == ST_DONE);
        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign resp_data  = data_q;

endmodule
